bcd_to_bin_seq: RTL

//  Sequential BCD-to-binary converter (reverse double-dabble). Consumes packed BCD results

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_to_bin_seq_if.sv | 25 ++
 rtl/bcd_digit_corr.sv | 13 +
 rtl/bcd_to_bin_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  BCD_CORR  = 4'd3;
    localparam logic [3:0]  BCD_THRESH = 4'd8;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Valid/ready handshake bundle between a BCD producer, the converter and its consumer.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      out_bin;
    logic                  out_err;

    // Environment side: supplies BCD words and consumes results
    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    // Converter side
    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_digit_corr.sv
// One-digit correction for reverse double-dabble: a digit of 8 or more after the
// right shift came from a borrowed "ten", so 3 is removed to restore BCD weight.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Digit is always >= 8 when corrected, so the 4-bit subtract cannot underflow
    assign digit_o = (digit_i >= BCD_THRESH) ? (digit_i - BCD_CORR) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one shift/correct step per clock,
// valid/ready on both sides, illegal digits flagged and forced to a zero result.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);

    localparam int     BCD_W   = DIGIT_W * DIGITS;
    localparam int     CNT_W   = $clog2(BIN_W + 1);
    localparam longint MAX_VAL = (64'sd10 ** DIGITS) - 64'sd1;

    // The largest BCD value must be representable in the binary result
    if (MAX_VAL >= (64'sd1 <<< BIN_W)) begin : g_width_check
        $error("BIN_W too small to hold 10**DIGITS-1");
    end

    state_e              state_q, state_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [BCD_W-1:0]    bcd_shift;
    logic [BCD_W-1:0]    bcd_corr;
    logic [BIN_W-1:0]    bin_shift;
    logic                in_err;

    // BCD LSB falls into the binary MSB; BCD MSB fills with zero
    assign bcd_shift = bcd_q >> 1;
    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit_i (bcd_shift[g*DIGIT_W +: DIGIT_W]),
            .digit_o (bcd_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Flag any incoming digit outside 0..9
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[i*DIGIT_W +: DIGIT_W] > BCD_MAX) in_err = 1'b1;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    bcd_d   = bus.in_bcd;
                    bin_d   = '0;
                    cnt_d   = '0;
                    err_d   = in_err;
                    state_d = in_err ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_corr;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_bin   = (state_q == ST_DONE) ? bin_q : '0;
    assign bus.out_err   = (state_q == ST_DONE) ? err_q : 1'b0;

    // A legal input must have been fully drained out of the BCD register
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_DONE && !err_q) assert (bcd_q == '0);
    end

endmodule
